ntt_coeff_loader: RTL and testbench
===================================

Name: ntt_coeff_loader

Overview:
- Input stage that feeds the 8-point naive NTT core.
- Accepts a configuration (omega, modulus) and a stream of 8-bit coefficients over a valid/ready handshake.
- Reduces each coefficient modulo the configured modulus with a sequential restoring-remainder unit, then packs 8 reduced coefficients into the 64-bit word the NTT core consumes.
- Presents that word, plus the latched omega/mod, on a valid/ready output.

Parameters:
- N, 8, number of coefficients per frame (slot counter is 3 bits for N=8).
- W, 8, coefficient, omega and modulus width in bits.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a frame; sampled only in IDLE.
- cfg_omega  in  W  twiddle root, latched on accepted start.
- cfg_mod  in  W  modulus q, latched on accepted start.
- cfg_err  out  1  one-cycle pulse: start rejected because cfg_mod==0.
- s_valid  in  1  coefficient valid.
- s_ready  out  1  loader can accept a coefficient.
- s_coeff  in  W  raw coefficient, unsigned.
- s_last  in  1  marks final coefficient of a short frame.
- m_valid  out  1  packed frame valid.
- m_ready  in  1  downstream accepts frame.
- m_data  out  N*W  packed frame; slot k at bits [8k+7:8k].
- m_omega  out  W  latched omega for this frame.
- m_mod  out  W  latched modulus for this frame.
- m_short  out  1  frame was closed early by s_last; zero-padded.

Behaviour:
- Reset (synchronous rst=1): state=IDLE; s_ready, m_valid, m_short, cfg_err = 0; m_data, m_omega, m_mod = 0; slot counter = 0. rst mid-frame discards the partial frame. rst overrides every other input.
- State IDLE, on start=1:
  - cfg_mod==0: cfg_err=1 for the next cycle only; remain in IDLE.
  - otherwise: latch omega/mod, clear buffer and slot counter, go to LOAD.
- State LOAD:
  - s_ready=1 (registered, asserted only in LOAD).
  - On s_valid&&s_ready: capture s_coeff and s_last; go to REDUCE.
- State REDUCE: 8 cycles of restoring remainder over the coefficient, MSB first. Per cycle:
  - rem = (rem<<1) | bit.
  - if rem >= mod, then rem = rem - mod.
  - rem is 9 bits wide to hold the shifted intermediate; the result is always < mod.
  - On the 8th cycle, write rem into the current slot.
  - Branch: if slot==N-1 or captured s_last, go to OUT; else increment slot and go to LOAD.
- Timing:
  - Coefficient accepted in cycle A gives s_ready=0 in A+1..A+8.
  - Either s_ready=1 again in A+9, or m_valid=1 in A+9 if the frame is complete.
- State OUT:
  - m_valid=1.
  - m_data, m_omega, m_mod and m_short are held stable until m_valid&&m_ready.
  - On that handshake, go to IDLE and drop m_valid on the next cycle.
- Short frame: s_last on slot k<N-1 leaves slots k+1..N-1 = 0 and sets m_short=1. s_last on slot N-1 is ignored; m_short=0.
- start outside IDLE is ignored. s_valid outside LOAD is ignored; no coefficient is consumed.
- mod==1: every slot reduces to 0. Coefficients already < mod pass unchanged.

Decomposition:
- Shared package ntt_pkg:
  - constants N and W, and the frame width N*W;
  - state encoding IDLE/LOAD/REDUCE/OUT;
  - slot-to-bit-range helper constant.
- One sub-module, ntt_mod_reduce_seq:
  - inputs: start, value, mod;
  - outputs: done after exactly 8 cycles, and rem;
  - the loader FSM instantiates it once.

Test Plan:
- start with mod=17, omega=3; coeffs 0..7, no stalls:
  - m_data=0x0706050403020100, m_omega=3, m_mod=17, m_short=0;
  - m_valid rises 9 cycles after the 8th accept.
- mod=17; coeffs 255,17,16,34,200,1,18,100 -> m_data=0x0F01010D00100000.
- mod=17; coeffs 5,6,7 with s_last on 7 -> m_data=0x0000000000070605, m_short=1.
- start with cfg_mod=0 -> cfg_err=1 for exactly one cycle; state stays IDLE; s_ready stays 0; a later start with mod=5 is accepted.
- Output backpressure: after a full frame, hold m_ready=0 for 10 cycles while pulsing start and s_valid:
  - m_valid stays 1; m_data is unchanged; s_ready stays 0;
  - m_ready=1 completes the transfer; IDLE is entered the next cycle.
- rst=1 for one cycle during the 4th cycle of REDUCE on slot 2:
  - next cycle: all outputs at reset values;
  - a fresh 8-coefficient frame then produces the correct packing.

Source files
------------

// File: rtl/ntt_pkg.sv
// ---------------------------------------------------------------------------
// ntt_pkg
// Shared constants and types for the NTT coefficient loader slice.
//   N        : coefficients per frame
//   W        : coefficient / omega / modulus width
//   FRAME_W  : packed frame width (N*W)
//   SLOT_W   : width of the slot counter
//   state_t  : loader FSM state encoding
//   slot_lo(): lowest bit of a slot inside the packed frame
// ---------------------------------------------------------------------------
package ntt_pkg;

   localparam int N           = 8;
   localparam int W           = 8;
   localparam int FRAME_W     = N * W;
   localparam int SLOT_W      = $clog2(N);
   localparam int SLOT_STRIDE = W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      REDUCE = 2'd2,
      OUT    = 2'd3
   } state_t;

   // Slot k occupies bits [k*w + w-1 : k*w] of the packed frame.
   function automatic int slot_lo(input int slot, input int w);
      return slot * w;
   endfunction

endpackage

// File: rtl/ntt_mod_reduce_seq.sv
// ---------------------------------------------------------------------------
// ntt_mod_reduce_seq
// Sequential restoring-remainder unit: value mod m, one bit per cycle, MSB
// first. A start pulse loads the operand; done is asserted during the W-th
// working cycle, with rem already holding the final remainder in that cycle.
//   clk, rst : clock, synchronous active-high reset
//   start    : load value and begin reduction
//   value    : unsigned operand
//   mod      : modulus (non-zero, stable for the whole reduction)
//   done     : high for exactly one cycle, W cycles after start
//   rem      : value mod mod, valid while done is high
// ---------------------------------------------------------------------------
module ntt_mod_reduce_seq #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] value,
   input  logic [W-1:0] mod,
   output logic         done,
   output logic [W-1:0] rem
);
   import ntt_pkg::*;

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   logic          busy;
   logic [CW-1:0] cnt;
   logic [W-1:0]  val_sh;
   logic [W-1:0]  rem_q;
   logic [W:0]    shifted;
   logic          ge;

   // One restoring step: rem_q < mod always, so shifted < 2*mod fits W+1 bits
   // and a single conditional subtract restores the invariant.
   always_comb begin
      shifted = {rem_q, val_sh[W-1]};
      ge      = (shifted >= {1'b0, mod});
      rem     = ge ? W'(shifted - {1'b0, mod}) : shifted[W-1:0];
      done    = busy && (cnt == CW'(W - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= '0;
      end else if (busy) begin
         cnt <= cnt + CW'(1);
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

   // Operand shift register and partial remainder carry no reset.
   always_ff @(posedge clk) begin
      if (start) begin
         val_sh <= value;
         rem_q  <= '0;
      end else if (busy) begin
         val_sh <= {val_sh[W-2:0], 1'b0};
         rem_q  <= rem;
      end
   end

endmodule

// File: rtl/ntt_coeff_loader.sv
// ---------------------------------------------------------------------------
// ntt_coeff_loader
// Input stage for the 8-point NTT core. Latches (omega, mod) on start,
// accepts coefficients over valid/ready, reduces each one modulo mod with a
// bit-serial remainder unit and packs N results into one frame word.
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a frame (honoured only in IDLE)
//   cfg_omega, cfg_mod  : configuration latched on an accepted start
//   cfg_err             : one-cycle pulse when start carried cfg_mod==0
//   s_valid/s_ready     : coefficient handshake
//   s_coeff, s_last     : raw coefficient and early end-of-frame marker
//   m_valid/m_ready     : frame handshake
//   m_data              : packed frame, slot k at bits [W*k+W-1:W*k]
//   m_omega, m_mod      : configuration of this frame
//   m_short             : frame closed early by s_last, tail zero-padded
// ---------------------------------------------------------------------------
module ntt_coeff_loader #(
   parameter int N = 8,
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   cfg_omega,
   input  logic [W-1:0]   cfg_mod,
   output logic           cfg_err,
   input  logic           s_valid,
   output logic           s_ready,
   input  logic [W-1:0]   s_coeff,
   input  logic           s_last,
   output logic           m_valid,
   input  logic           m_ready,
   output logic [N*W-1:0] m_data,
   output logic [W-1:0]   m_omega,
   output logic [W-1:0]   m_mod,
   output logic           m_short
);
   import ntt_pkg::*;

   localparam int SW = (N > 1) ? $clog2(N) : 1;

   state_t        state;
   state_t        state_next;
   logic [SW-1:0] slot;
   logic          last_q;

   logic          cfg_ok;
   logic          cfg_bad;
   logic          coeff_acc;
   logic          slot_wr;
   logic          slot_full;

   logic          red_done;
   logic [W-1:0]  red_rem;

   // m_mod is the latched modulus and stays stable for the whole frame.
   ntt_mod_reduce_seq #(
      .W(W)
   ) u_reduce (
      .clk  (clk),
      .rst  (rst),
      .start(coeff_acc),
      .value(s_coeff),
      .mod  (m_mod),
      .done (red_done),
      .rem  (red_rem)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start && (cfg_mod != '0)) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            if (s_valid && s_ready) begin
               state_next = REDUCE;
            end
         end
         REDUCE: begin
            if (red_done) begin
               state_next = (slot_full || last_q) ? OUT : LOAD;
            end
         end
         OUT: begin
            if (m_valid && m_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output / strobe decode
   always_comb begin
      cfg_ok    = (state == IDLE) && start && (cfg_mod != '0);
      cfg_bad   = (state == IDLE) && start && (cfg_mod == '0);
      coeff_acc = (state == LOAD) && s_valid && s_ready;
      slot_wr   = (state == REDUCE) && red_done;
      slot_full = (slot == SW'(N - 1));
   end

   // Registered handshakes follow the next state so that s_ready and m_valid
   // are flops yet line up exactly with LOAD and OUT.
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_err <= 1'b0;
         s_ready <= 1'b0;
         m_valid <= 1'b0;
         m_short <= 1'b0;
         m_data  <= '0;
         m_omega <= '0;
         m_mod   <= '0;
         slot    <= '0;
         last_q  <= 1'b0;
      end else begin
         cfg_err <= cfg_bad;
         s_ready <= (state_next == LOAD);
         m_valid <= (state_next == OUT);

         if (cfg_ok) begin
            m_omega <= cfg_omega;
            m_mod   <= cfg_mod;
            m_data  <= '0;
            m_short <= 1'b0;
            slot    <= '0;
         end

         if (coeff_acc) begin
            last_q <= s_last;
         end

         // s_last on the final slot is redundant: the frame is full anyway
         // and is not flagged short.
         if (slot_wr) begin
            m_data[slot_lo(int'(slot), W) +: W] <= red_rem;
            if (!slot_full) begin
               if (last_q) begin
                  m_short <= 1'b1;
               end else begin
                  slot <= slot + SW'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ntt_coeff_loader.sv
module tb_ntt_coeff_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  cfg_omega;
   logic [7:0]  cfg_mod;
   logic        cfg_err;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_coeff;
   logic        s_last;
   logic        m_valid;
   logic        m_ready;
   logic [63:0] m_data;
   logic [7:0]  m_omega;
   logic [7:0]  m_mod;
   logic        m_short;

   ntt_coeff_loader #(.N(8), .W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .cfg_omega(cfg_omega),
      .cfg_mod  (cfg_mod),
      .cfg_err  (cfg_err),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_coeff  (s_coeff),
      .s_last   (s_last),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .m_omega  (m_omega),
      .m_mod    (m_mod),
      .m_short  (m_short)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]  omega;
      logic [7:0]  mod;
      logic [7:0]  c [8];
      int          n;
      int          last_idx;
      logic [63:0] exp_data;
      logic        exp_short;
   } vec_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  omega;
      logic [7:0]  mod;
      logic        short_f;
   } exp_t;

   exp_t exp_q[$];
   vec_t tab[7];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input logic [63:0] d, input logic [7:0] o, input logic [7:0] m,
                           input logic s);
      exp_t e;
      e.data    = d;
      e.omega   = o;
      e.mod     = m;
      e.short_f = s;
      exp_q.push_back(e);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
      check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
      check({tag, "_m_short"}, 64'(m_short), 64'd0);
      check({tag, "_cfg_err"}, 64'(cfg_err), 64'd0);
      check({tag, "_m_data"},  m_data,       64'd0);
      check({tag, "_m_omega"}, 64'(m_omega), 64'd0);
      check({tag, "_m_mod"},   64'(m_mod),   64'd0);
   endtask

   // All tasks enter and leave aligned to a falling edge.
   task automatic start_cfg(input logic [7:0] o, input logic [7:0] m);
      start     = 1'b1;
      cfg_omega = o;
      cfg_mod   = m;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic send_coeff(input logic [7:0] c, input logic last, input bit wait_done,
                             output int lat);
      int k;
      int a;
      lat = -1;
      k = 0;
      while (!s_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("s_ready_wait", 64'(s_ready), 64'd1);
      s_valid = 1'b1;
      s_coeff = c;
      s_last  = last;
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      a = cyc;
      if (wait_done) begin
         k = 0;
         while (!s_ready && !m_valid && k < 50) begin
            @(negedge clk);
            k++;
         end
         lat = cyc - a;
      end
   endtask

   task automatic check_frame();
      exp_t e;
      int   k;
      k = 0;
      while (!m_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("m_valid_wait", 64'(m_valid), 64'd1);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard: frame seen, none expected (cycle %0d)", cyc);
      end else begin
         e = exp_q.pop_front();
         check("m_data",  m_data,       e.data);
         check("m_omega", 64'(m_omega), 64'(e.omega));
         check("m_mod",   64'(m_mod),   64'(e.mod));
         check("m_short", 64'(m_short), 64'(e.short_f));
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      check("m_valid_drop", 64'(m_valid), 64'd0);
      check("s_ready_idle", 64'(s_ready), 64'd0);
   endtask

   task automatic run_frame(input vec_t v);
      int lat;
      start_cfg(v.omega, v.mod);
      check("s_ready_after_start", 64'(s_ready), 64'd1);
      push_exp(v.exp_data, v.omega, v.mod, v.exp_short);
      for (int i = 0; i < v.n; i++) begin
         send_coeff(v.c[i], (i == v.last_idx), 1'b1, lat);
         check("coeff_latency", 64'(lat), 64'd8);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;

      tab[0] = '{8'd3,   8'd17,  '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7},
                 8, -1, 64'h0706050403020100, 1'b0};
      tab[1] = '{8'd3,   8'd17,  '{8'd255, 8'd17, 8'd16, 8'd34, 8'd200, 8'd1, 8'd18, 8'd100},
                 8, -1, 64'h0F01010D00100000, 1'b0};
      tab[2] = '{8'd3,   8'd17,  '{8'd5, 8'd6, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                 3, 2, 64'h0000000000070605, 1'b1};
      tab[3] = '{8'd9,   8'd1,   '{8'd255, 8'd1, 8'd0, 8'd77, 8'd128, 8'd3, 8'd200, 8'd9},
                 8, -1, 64'h0000000000000000, 1'b0};
      tab[4] = '{8'hFF,  8'd255, '{8'd254, 8'd255, 8'd0, 8'd128, 8'd1, 8'd100, 8'd200, 8'd7},
                 8, -1, 64'h07C86401800000FE, 1'b0};
      tab[5] = '{8'd2,   8'd5,   '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17},
                 8, 7, 64'h0201000403020100, 1'b0};
      tab[6] = '{8'd5,   8'd200, '{8'd250, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                 1, 0, 64'h0000000000000032, 1'b1};

      rst       = 1'b1;
      start     = 1'b0;
      cfg_omega = '0;
      cfg_mod   = '0;
      s_valid   = 1'b0;
      s_coeff   = '0;
      s_last    = 1'b0;
      m_ready   = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      check("idle_s_ready", 64'(s_ready), 64'd0);

      // Table-driven frames
      for (int t = 0; t < 7; t++) begin
         run_frame(tab[t]);
         check_frame();
      end

      // Zero modulus is rejected with a single-cycle error pulse
      cfg_omega = 8'd4;
      cfg_mod   = 8'd0;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      check("cfg_err_pulse", 64'(cfg_err), 64'd1);
      check("cfg_err_s_ready", 64'(s_ready), 64'd0);
      @(negedge clk);
      check("cfg_err_clear", 64'(cfg_err), 64'd0);
      repeat (3) @(negedge clk);
      check("cfg_err_stay_idle", 64'(s_ready), 64'd0);
      start_cfg(8'd4, 8'd5);
      check("restart_mod5", 64'(s_ready), 64'd1);
      push_exp(64'h0000000000000302, 8'd4, 8'd5, 1'b1);
      send_coeff(8'd7, 1'b0, 1'b1, lat);
      check("mod5_lat0", 64'(lat), 64'd8);
      send_coeff(8'd3, 1'b1, 1'b1, lat);
      check("mod5_lat1", 64'(lat), 64'd8);
      check_frame();

      // Output backpressure while start and s_valid are driven
      start_cfg(8'd7, 8'd11);
      push_exp(64'h0504030201000A09, 8'd7, 8'd11, 1'b0);
      for (int i = 0; i < 8; i++) begin
         send_coeff(8'(20 + i), 1'b0, 1'b1, lat);
         check("bp_latency", 64'(lat), 64'd8);
      end
      check("bp_m_valid_up", 64'(m_valid), 64'd1);
      for (int i = 0; i < 10; i++) begin
         start     = (i % 2 == 0);
         cfg_omega = 8'd1;
         cfg_mod   = 8'd9;
         s_valid   = 1'b1;
         s_coeff   = 8'hAA;
         @(negedge clk);
         check("bp_m_valid_hold", 64'(m_valid), 64'd1);
         check("bp_m_data_hold", m_data, 64'h0504030201000A09);
         check("bp_s_ready_low", 64'(s_ready), 64'd0);
      end
      start   = 1'b0;
      s_valid = 1'b0;
      check("bp_m_omega_hold", 64'(m_omega), 64'd7);
      check_frame();
      @(negedge clk);
      check("bp_no_stray_start", 64'(s_ready), 64'd0);

      // Reset during the 4th reduction cycle of slot 2
      start_cfg(8'd3, 8'd17);
      send_coeff(8'd40, 1'b0, 1'b1, lat);
      send_coeff(8'd41, 1'b0, 1'b1, lat);
      send_coeff(8'd42, 1'b0, 1'b0, lat);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("midrst");
      repeat (12) @(negedge clk);
      check("midrst_no_valid", 64'(m_valid), 64'd0);
      check("midrst_no_ready", 64'(s_ready), 64'd0);
      run_frame(tab[0]);
      check_frame();

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
